// File: rtl/bsg_fma_norm_round_pkg.sv
// Shared FMA constants, special-value encodings and the normalize-stage record.
package bsg_fma_norm_round_pkg;

    localparam int exp_p      = 8;
    localparam int sig_p      = 23;
    localparam int width_lp   = exp_p + sig_p + 1;
    localparam int sig_w_lp   = 2*sig_p + 2;
    localparam int bias_lp    = 2**(exp_p-1) - 1;
    localparam int exp_max_lp = 2**exp_p - 1;

    function automatic logic [width_lp-1:0] nan_val();
        return {1'b0, {exp_p{1'b1}}, 1'b1, {(sig_p-1){1'b0}}};
    endfunction

    function automatic logic [width_lp-1:0] inf_val(input logic sign);
        return {sign, {exp_p{1'b1}}, {sig_p{1'b0}}};
    endfunction

    // exp is a two's-complement value; reinterpret with $signed where compared
    typedef struct packed {
        logic               sign;
        logic [exp_p+1:0]   exp;
        logic [sig_p-1:0]   frac;
        logic               guard;
        logic               sticky;
        logic               nan;
        logic               inf;
        logic               zero;
    } norm_s;

endpackage

// File: rtl/bsg_fma_round_rne.sv
// Round-to-nearest-even on a normalized fraction; a fraction carry bumps the exponent.
module bsg_fma_round_rne
    import bsg_fma_norm_round_pkg::*;
(
    input  logic [sig_p-1:0] frac_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic [exp_p+1:0] exp_i,
    output logic [sig_p-1:0] frac_o,
    output logic [exp_p+1:0] exp_o,
    output logic             inexact_o
);

    logic           round_up;
    logic [sig_p:0] sum;

    assign round_up  = guard_i & (sticky_i | frac_i[0]);
    assign sum       = {1'b0, frac_i} + {{sig_p{1'b0}}, round_up};
    // on carry the low bits of sum are already all zero
    assign frac_o    = sum[sig_p-1:0];
    assign exp_o     = exp_i + {{(exp_p+1){1'b0}}, sum[sig_p]};
    assign inexact_o = guard_i | sticky_i;

endmodule

// File: rtl/bsg_fma_norm_round.sv
// Two-stage normalize/round back end of the FMA with valid/ready flow control.
module bsg_fma_norm_round
    import bsg_fma_norm_round_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                v_i,
    output logic                ready_o,
    input  logic                sign_i,
    input  logic [exp_p+1:0]    exp_i,
    input  logic [sig_w_lp-1:0] sig_i,
    input  logic                nan_i,
    input  logic                inf_i,
    input  logic                zero_i,
    output logic                v_o,
    input  logic                ready_i,
    output logic [width_lp-1:0] z_o,
    output logic                overflow_o,
    output logic                underflow_o,
    output logic                inexact_o
);

    localparam int m_lp = 2*sig_p + 1;
    localparam logic signed [exp_p+1:0] exp_top_lp  = (exp_p+2)'(exp_max_lp);
    localparam logic signed [exp_p+1:0] exp_zero_lp = '0;

    norm_s s1_n, s1_q;
    logic  s1_v, s2_v;
    logic  s1_load, s2_load;

    // a stage loads when empty or when its contents move on this cycle
    assign s2_load = !s2_v | ready_i;
    assign s1_load = !s1_v | s2_load;
    assign ready_o = s1_load;

    always_comb begin
        s1_n      = '0;
        s1_n.sign = sign_i;
        s1_n.nan  = nan_i;
        s1_n.inf  = inf_i;
        s1_n.zero = zero_i;
        if (sig_i[m_lp]) begin
            s1_n.frac   = sig_i[m_lp-1:sig_p+1];
            s1_n.guard  = sig_i[sig_p];
            s1_n.sticky = |sig_i[sig_p-1:0];
            s1_n.exp    = exp_i + (exp_p+2)'(1);
        end else begin
            s1_n.frac   = sig_i[m_lp-2:sig_p];
            s1_n.guard  = sig_i[sig_p-1];
            s1_n.sticky = |sig_i[sig_p-2:0];
            s1_n.exp    = exp_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_load) begin
            s1_v <= v_i;
            if (v_i) s1_q <= s1_n;
        end
    end

    logic [sig_p-1:0]        frac_r;
    logic [exp_p+1:0]        exp_r;
    logic signed [exp_p+1:0] exp_rs;
    logic                    ix_r;

    bsg_fma_round_rne round_rne (
        .frac_i    (s1_q.frac),
        .guard_i   (s1_q.guard),
        .sticky_i  (s1_q.sticky),
        .exp_i     (s1_q.exp),
        .frac_o    (frac_r),
        .exp_o     (exp_r),
        .inexact_o (ix_r)
    );

    assign exp_rs = exp_r;

    logic [width_lp-1:0] z_n;
    logic                ov_n, un_n, ix_n;

    always_comb begin
        z_n  = '0;
        ov_n = 1'b0;
        un_n = 1'b0;
        ix_n = 1'b0;
        if (s1_q.nan | (s1_q.inf & s1_q.zero)) begin
            z_n = nan_val();
        end else if (s1_q.inf) begin
            z_n = inf_val(s1_q.sign);
        end else if (s1_q.zero) begin
            z_n = {s1_q.sign, {(width_lp-1){1'b0}}};
        end else if (exp_rs >= exp_top_lp) begin
            z_n  = inf_val(s1_q.sign);
            ov_n = 1'b1;
            ix_n = 1'b1;
        end else if (exp_rs <= exp_zero_lp) begin
            // no subnormals: anything below the normal range flushes to zero
            z_n  = {s1_q.sign, {(width_lp-1){1'b0}}};
            un_n = 1'b1;
            ix_n = 1'b1;
        end else begin
            z_n  = {s1_q.sign, exp_r[exp_p-1:0], frac_r};
            ix_n = ix_r;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_v        <= 1'b0;
            z_o         <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                z_o         <= z_n;
                overflow_o  <= ov_n;
                underflow_o <= un_n;
                inexact_o   <= ix_n;
            end
        end
    end

    assign v_o = s2_v;

endmodule

// File: tb/tb_bsg_fma_norm_round.sv
// Bench for bsg_fma_norm_round: directed corner cases plus randomized traffic vs. an arithmetic model.
module tb_bsg_fma_norm_round;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_o;
    logic        sign_i;
    logic [9:0]  exp_i;
    logic [47:0] sig_i;
    logic        nan_i, inf_i, zero_i;
    logic        v_o;
    logic        ready_i;
    logic [31:0] z_o;
    logic        overflow_o, underflow_o, inexact_o;

    bsg_fma_norm_round dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .sig_i       (sig_i),
        .nan_i       (nan_i),
        .inf_i       (inf_i),
        .zero_i      (zero_i),
        .v_o         (v_o),
        .ready_i     (ready_i),
        .z_o         (z_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .inexact_o   (inexact_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // result = {z[31:0], overflow, underflow, inexact}
    function automatic logic [34:0] ref_model(input logic s, input logic signed [9:0] e_in,
                                              input logic [47:0] sig, input logic n,
                                              input logic i, input logic z);
        longint e, shift, mant, rem, half, sv;
        logic   up, ix;
        logic [31:0] r;
        if (n || (i && z)) return {32'h7FC00000, 3'b000};
        if (i) return {s, 8'hFF, 23'd0, 3'b000};
        if (z) return {s, 31'd0, 3'b000};
        sv    = longint'(sig);
        shift = (sv >= (longint'(1) << 47)) ? 24 : 23;
        mant  = sv >> shift;
        rem   = sv & ((longint'(1) << shift) - 1);
        half  = longint'(1) << (shift - 1);
        e     = longint'(e_in) + ((shift == 24) ? 1 : 0);
        up    = (rem > half) || (rem == half && (mant % 2 == 1));
        mant  = mant + (up ? 1 : 0);
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        ix = (rem != 0);
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (e <= 0) return {s, 31'd0, 3'b011};
        r = {s, 8'(e), 23'(mant)};
        return {r, 2'b00, ix};
    endfunction

    logic [34:0] sb_q[$];
    logic        in_hs = 1'b0;
    int          out_cnt = 0;
    logic        held_v = 1'b0;
    logic [34:0] held_val;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            in_hs  = 1'b0;
            held_v = 1'b0;
        end else begin
            if (held_v) chk("hold_stable", {z_o, overflow_o, underflow_o, inexact_o}, held_val);
            held_v   = v_o && !ready_i;
            held_val = {z_o, overflow_o, underflow_o, inexact_o};
            if (v_o && ready_i) begin
                if (sb_q.size() == 0) chk("sb_empty", 1, 0);
                else chk("sb_out", {z_o, overflow_o, underflow_o, inexact_o}, sb_q.pop_front());
                out_cnt++;
            end
            in_hs = v_i && ready_o;
            if (in_hs) sb_q.push_back(ref_model(sign_i, exp_i, sig_i, nan_i, inf_i, zero_i));
        end
    end

    task automatic set_in(input logic s, input logic [9:0] e, input logic [47:0] sg,
                          input logic n, input logic i, input logic z);
        sign_i = s; exp_i = e; sig_i = sg; nan_i = n; inf_i = i; zero_i = z;
    endtask

    task automatic gen_item(output logic s, output logic [9:0] e, output logic [47:0] sg,
                            output logic n, output logic i, output logic z);
        logic [23:0] a, b;
        int mode;
        a    = {1'b1, 23'($urandom)};
        b    = {1'b1, 23'($urandom)};
        sg   = 48'(a) * 48'(b);
        s    = 1'($urandom);
        e    = 10'(int'($urandom_range(0, 1000)) - 500);
        n    = 1'b0; i = 1'b0; z = 1'b0;
        mode = int'($urandom_range(0, 9));
        case (mode)
            6: sg[21:0] = '0;
            7: e = 10'(253 + int'($urandom_range(0, 2)));
            8: e = 10'(int'($urandom_range(0, 2)) - 1);
            9: {n, i, z} = 3'($urandom);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        v_i = 1'b0;
        ready_i = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
    endtask

    task automatic directed(input string tag, input logic s, input logic [9:0] e, input logic [47:0] sg,
                            input logic n, input logic i, input logic z, input logic [34:0] expv);
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        set_in(s, e, sg, n, i, z);
        v_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_rdy"}, 64'(ready_o), 1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, "_v"}, 64'(v_o), 1);
        chk(tag, {z_o, overflow_o, underflow_o, inexact_o}, expv);
    endtask

    logic        bs[4];
    logic [9:0]  be[4];
    logic [47:0] bg[4];
    logic        bn[4], bi[4], bz[4];

    initial begin
        int acc, out0, guard_cnt;
        logic s, n, i, z;
        logic [9:0] e;
        logic [47:0] sg;

        reset_n_i = 1'b0;
        set_in(0, '0, '0, 0, 0, 0);
        do_reset();
        chk("rst_v_o", 64'(v_o), 0);
        chk("rst_ready_o", 64'(ready_o), 1);
        chk("rst_z_o", 64'({z_o, overflow_o, underflow_o, inexact_o}), 0);

        directed("mul_1p5", 0, 10'd127, 48'h900000000000, 0, 0, 0, {32'h40100000, 3'b000});
        directed("tie_even", 0, 10'd100, 48'h7FFFFFC00000, 0, 0, 0, {32'h32800000, 3'b001});
        directed("ovf", 0, 10'd254, 48'h900000000000, 0, 0, 0, {32'h7F800000, 3'b101});
        directed("unf", 1, 10'd0, 48'h400000000000, 0, 0, 0, {32'h80000000, 3'b011});
        directed("inf_x_zero", 1, 10'd50, 48'h400000000000, 0, 1, 1, {32'h7FC00000, 3'b000});
        directed("neg_inf", 1, 10'd50, 48'h400000000000, 0, 1, 0, {32'hFF800000, 3'b000});
        directed("nan_inf", 0, 10'd50, 48'h400000000000, 1, 1, 0, {32'h7FC00000, 3'b000});
        directed("neg_zero", 1, 10'd50, 48'h400000000000, 0, 0, 1, {32'h80000000, 3'b000});

        // backpressure: four items offered while the sink stalls
        for (int k = 0; k < 4; k++) gen_item(bs[k], be[k], bg[k], bn[k], bi[k], bz[k]);
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            set_in(bs[acc], be[acc], bg[acc], bn[acc], bi[acc], bz[acc]);
            v_i = 1'b1;
            @(negedge clk_i);
            if (ready_o) acc++;
            @(posedge clk_i); #1;
        end
        chk("bp_accepted", 64'(acc), 2);
        chk("bp_ready_low", 64'(ready_o), 0);
        chk("bp_v_o", 64'(v_o), 1);
        out0 = out_cnt;
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (acc < 4) begin
                set_in(bs[acc], be[acc], bg[acc], bn[acc], bi[acc], bz[acc]);
                v_i = 1'b1;
            end else v_i = 1'b0;
            @(negedge clk_i);
            if (v_i && ready_o) acc++;
            @(posedge clk_i); #1;
        end
        v_i = 1'b0;
        chk("bp_all_in", 64'(acc), 4);
        chk("bp_drain_rate", 64'(out_cnt - out0), 4);

        // reset with both stages occupied
        ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            gen_item(s, e, sg, n, i, z);
            set_in(s, e, sg, n, i, z);
            v_i = 1'b1;
            @(posedge clk_i); #1;
        end
        v_i = 1'b0;
        chk("full_v_o", 64'(v_o), 1);
        chk("full_ready_o", 64'(ready_o), 0);
        #1 reset_n_i = 1'b0;
        #1;
        chk("midrst_v_o", 64'(v_o), 0);
        chk("midrst_ready_o", 64'(ready_o), 1);
        chk("midrst_z", 64'({z_o, overflow_o, underflow_o, inexact_o}), 0);
        sb_q.delete();
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        ready_i = 1'b1;
        directed("after_rst", 0, 10'd127, 48'h900000000000, 0, 0, 0, {32'h40100000, 3'b000});

        // randomized traffic with random backpressure
        v_i = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk_i); #1;
            ready_i = ($urandom_range(0, 3) != 0);
            if (!v_i || in_hs) begin
                if ($urandom_range(0, 3) != 0) begin
                    gen_item(s, e, sg, n, i, z);
                    set_in(s, e, sg, n, i, z);
                    v_i = 1'b1;
                end else v_i = 1'b0;
            end
        end
        @(posedge clk_i); #1;
        if (in_hs) v_i = 1'b0;
        else begin
            ready_i = 1'b1;
            guard_cnt = 0;
            while (!in_hs && guard_cnt < 10) begin
                @(posedge clk_i); #1;
                guard_cnt++;
            end
            v_i = 1'b0;
        end
        ready_i = 1'b1;
        guard_cnt = 0;
        while (sb_q.size() != 0 && guard_cnt < 20) begin
            @(posedge clk_i); #1;
            guard_cnt++;
        end
        chk("drain_empty", 64'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
